// File: rtl/tmnt_pkg.sv
// Shared types and constants for the sound-command path between the 68k and the Z80.
package tmnt_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_ASSERT = 2'd1,
    IRQ_ACK    = 2'd2
  } irq_state_e;

  localparam logic [7:0] RST38_VEC = 8'hFF;

endpackage

// File: rtl/cmd_fifo.sv
// Command byte storage: an overwrite register at DEPTH=1, otherwise a power-of-2 FIFO.
// The output shows the head entry, or the last popped byte while empty.
module cmd_fifo #(
  parameter int DEPTH = 1
) (
  input  logic                    clk_main,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [7:0]              din_i,
  output logic [7:0]              dout_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    ovf_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    last_q, last_d;
  logic [7:0]    head;
  logic          full, empty, do_push, do_pop, write_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    do_push  = push_i && (!full || do_pop);
    // the single latch always takes the new byte, even over unread data
    write_en = (DEPTH == 1) ? push_i : do_push;
    ovf_o    = push_i && full && !do_pop;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    last_d   = last_q;
    if (do_pop) begin
      last_d = head;
      if (DEPTH > 1) rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && DEPTH > 1) wr_ptr_d = wr_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (write_en) mem_q[wr_ptr_q] <= din_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  assign dout_o  = empty ? last_q : head;
  assign count_o = count_q;

endmodule

// File: rtl/sound_cmd_latch.sv
// Z80-side sound-command receiver: latches 68k command bytes and raises the Z80 INT on SNDON edges.
//   state      | meaning
//   IRQ_IDLE   | no interrupt outstanding
//   IRQ_ASSERT | z80_int_n driven low, waiting for the Z80 acknowledge cycle
//   IRQ_ACK    | acknowledge in progress, vector on z80_vec
module sound_cmd_latch
  import tmnt_pkg::*;
#(
  parameter int         DEPTH   = 1,
  parameter logic [7:0] IRQ_VEC = RST38_VEC
) (
  input  logic       clk_main,
  input  logic       reset,
  input  logic       snddt_n,
  input  logic       sndon,
  input  logic [7:0] cpu_din,
  input  logic       z80_rd_n,
  input  logic       z80_m1_n,
  input  logic       z80_iorq_n,
  output logic [7:0] z80_dout,
  output logic [7:0] z80_vec,
  output logic       ack_active,
  output logic       z80_int_n,
  output logic       pending,
  output logic       overrun
);

  logic snddt_q, snddt_hist_q, sndon_q, sndon_hist_q, rd_q, rd_hist_q;
  logic samp_vld_q, wr_block_q, wr_block_d;
  logic irq_pend_q, irq_pend_d, overrun_q;
  logic [7:0] din_q;
  irq_state_e state_q, state_d;

  logic snddt_rise, sndon_rise, rd_rise, commit, fifo_ovf;
  logic [$clog2(DEPTH):0] fifo_count;

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      snddt_q      <= 1'b1;
      snddt_hist_q <= 1'b1;
      sndon_q      <= 1'b1;
      sndon_hist_q <= 1'b1;
      rd_q         <= 1'b1;
      rd_hist_q    <= 1'b1;
      samp_vld_q   <= 1'b0;
      wr_block_q   <= 1'b1;
      din_q        <= '0;
      state_q      <= IRQ_IDLE;
      irq_pend_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      snddt_q      <= snddt_n;
      snddt_hist_q <= snddt_q;
      sndon_q      <= sndon;
      sndon_hist_q <= sndon_q;
      rd_q         <= z80_rd_n;
      rd_hist_q    <= rd_q;
      samp_vld_q   <= 1'b1;
      wr_block_q   <= wr_block_d;
      if (!snddt_n) din_q <= cpu_din;
      state_q      <= state_d;
      irq_pend_q   <= irq_pend_d;
      overrun_q    <= overrun_q | fifo_ovf;
    end
  end

  // A write strobe already low when reset lifts must not commit on its release:
  // commits stay blocked until a genuine high sample of snddt_n has been seen.
  assign wr_block_d = wr_block_q & ~(samp_vld_q & snddt_q);
  assign snddt_rise = snddt_q & ~snddt_hist_q;
  assign commit     = snddt_rise & ~wr_block_q;
  assign rd_rise    = rd_q & ~rd_hist_q;
  assign sndon_rise = sndon_q & ~sndon_hist_q;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_main (clk_main),
    .reset    (reset),
    .push_i   (commit),
    .pop_i    (rd_rise),
    .din_i    (din_q),
    .dout_o   (z80_dout),
    .count_o  (fifo_count),
    .ovf_o    (fifo_ovf)
  );

  always_comb begin
    state_d    = state_q;
    irq_pend_d = irq_pend_q;
    unique case (state_q)
      IRQ_IDLE: begin
        if (sndon_rise || irq_pend_q) begin
          state_d    = IRQ_ASSERT;
          irq_pend_d = 1'b0;
        end
      end
      IRQ_ASSERT: begin
        if (!z80_m1_n && !z80_iorq_n) state_d = IRQ_ACK;
      end
      IRQ_ACK: begin
        if (sndon_rise) irq_pend_d = 1'b1;
        if (z80_iorq_n) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  assign z80_int_n  = (state_q != IRQ_ASSERT);
  assign ack_active = (state_q == IRQ_ACK);
  assign z80_vec    = IRQ_VEC;
  assign pending    = (fifo_count != '0);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sound_cmd_latch.sv
// Bench for sound_cmd_latch: a single-latch and a 4-deep instance share stimulus and are
// checked against queue-based reference models plus a directed vector table.
module tb_sound_cmd_latch;

  logic       clk_main = 1'b0;
  logic       reset, snddt_n, sndon, z80_rd_n, z80_m1_n, z80_iorq_n;
  logic [7:0] cpu_din;
  logic [7:0] d1_dout, d1_vec, d4_dout, d4_vec;
  logic       d1_ack, d1_int_n, d1_pend, d1_ovr;
  logic       d4_ack, d4_int_n, d4_pend, d4_ovr;

  int total = 0;
  int bad   = 0;

  sound_cmd_latch #(.DEPTH(1)) u_d1 (
    .clk_main(clk_main), .reset(reset), .snddt_n(snddt_n), .sndon(sndon),
    .cpu_din(cpu_din), .z80_rd_n(z80_rd_n), .z80_m1_n(z80_m1_n), .z80_iorq_n(z80_iorq_n),
    .z80_dout(d1_dout), .z80_vec(d1_vec), .ack_active(d1_ack), .z80_int_n(d1_int_n),
    .pending(d1_pend), .overrun(d1_ovr)
  );

  sound_cmd_latch #(.DEPTH(4)) u_d4 (
    .clk_main(clk_main), .reset(reset), .snddt_n(snddt_n), .sndon(sndon),
    .cpu_din(cpu_din), .z80_rd_n(z80_rd_n), .z80_m1_n(z80_m1_n), .z80_iorq_n(z80_iorq_n),
    .z80_dout(d4_dout), .z80_vec(d4_vec), .ack_active(d4_ack), .z80_int_n(d4_int_n),
    .pending(d4_pend), .overrun(d4_ovr)
  );

  always #5 clk_main = ~clk_main;

  // reference models: plain queues of unread bytes
  logic [7:0] q1[$];
  logic [7:0] q4[$];
  logic [7:0] last1, last4;
  logic       ovr1, ovr4;

  typedef struct {
    bit         is_wr;
    logic [7:0] data;
    logic [7:0] dout4;
    bit         pend4;
    bit         ovr4;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    q1.delete(); q4.delete();
    last1 = 8'h00; last4 = 8'h00; ovr1 = 1'b0; ovr4 = 1'b0;
  endtask

  task automatic m_write(input logic [7:0] b);
    if (q1.size() == 1) begin ovr1 = 1'b1; q1[0] = b; end
    else q1.push_back(b);
    if (q4.size() == 4) ovr4 = 1'b1;
    else q4.push_back(b);
  endtask

  task automatic m_read();
    if (q1.size() > 0) last1 = q1.pop_front();
    if (q4.size() > 0) last4 = q4.pop_front();
  endtask

  task automatic check_data(input string tag);
    chk({tag, "_d1_dout"}, d1_dout, (q1.size() > 0) ? q1[0] : last1);
    chk({tag, "_d1_pend"}, d1_pend, q1.size() > 0);
    chk({tag, "_d1_ovr"},  d1_ovr,  ovr1);
    chk({tag, "_d4_dout"}, d4_dout, (q4.size() > 0) ? q4[0] : last4);
    chk({tag, "_d4_pend"}, d4_pend, q4.size() > 0);
    chk({tag, "_d4_ovr"},  d4_ovr,  ovr4);
  endtask

  task automatic check_irq(input string tag, input logic int_n, input logic ack);
    chk({tag, "_d1_int_n"}, d1_int_n, int_n);
    chk({tag, "_d1_ack"},   d1_ack,   ack);
    chk({tag, "_d4_int_n"}, d4_int_n, int_n);
    chk({tag, "_d4_ack"},   d4_ack,   ack);
    if (ack) chk({tag, "_vec"}, d4_vec, 8'hFF);
  endtask

  task automatic tick();
    @(posedge clk_main); #1;
  endtask

  task automatic do_write(input logic [7:0] b, input int low_cyc);
    cpu_din = b; snddt_n = 1'b0;
    repeat (low_cyc) tick();
    snddt_n = 1'b1; cpu_din = 8'($urandom);
    tick(); tick();
    m_write(b);
  endtask

  task automatic do_read();
    z80_rd_n = 1'b0; tick();
    z80_rd_n = 1'b1; tick(); tick();
    m_read();
  endtask

  task automatic do_both(input logic [7:0] b);
    cpu_din = b; snddt_n = 1'b0; z80_rd_n = 1'b0; tick();
    snddt_n = 1'b1; z80_rd_n = 1'b1; tick(); tick();
    m_read(); m_write(b);
  endtask

  task automatic ack_cycle();
    z80_m1_n = 1'b0; z80_iorq_n = 1'b0; tick();
    z80_m1_n = 1'b1; z80_iorq_n = 1'b1; tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 8'h01, 8'h01, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'h02, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h03, 8'h01, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h04, 8'h01, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h05, 8'h01, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 8'h02, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 8'h03, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 8'h04, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 8'h04, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 8'h04, 1'b0, 1'b1};

    reset = 1'b1; snddt_n = 1'b1; sndon = 1'b0; cpu_din = 8'h00;
    z80_rd_n = 1'b1; z80_m1_n = 1'b1; z80_iorq_n = 1'b1;
    m_reset();
    tick(); tick();
    check_data("reset");
    check_irq("reset", 1'b1, 1'b0);
    chk("reset_vec", d1_vec, 8'hFF);
    reset = 1'b0;
    tick(); tick();

    // single write with a 3-cycle strobe, pending appears two clocks after the rise
    cpu_din = 8'h5A; snddt_n = 1'b0;
    repeat (3) tick();
    snddt_n = 1'b1; cpu_din = 8'hC3;
    tick();
    chk("wr5a_early_pend", d4_pend, 1'b0);
    tick();
    m_write(8'h5A);
    chk("wr5a_dout", d4_dout, 8'h5A);
    chk("wr5a_pend", d4_pend, 1'b1);
    check_data("wr5a");
    do_read();
    check_data("rd5a");

    // single latch overwrite
    do_write(8'h11, 2);
    do_write(8'h22, 1);
    chk("ovw_d1_dout", d1_dout, 8'h22);
    chk("ovw_d1_ovr", d1_ovr, 1'b1);
    check_data("ovw");
    do_read();
    chk("ovw_rd_d1_pend", d1_pend, 1'b0);
    check_data("ovw_rd");
    do_read();
    check_data("drain");

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_wr) do_write(tbl[i].data, 2);
      else do_read();
      chk($sformatf("tbl%0d_d4_dout", i), d4_dout, tbl[i].dout4);
      chk($sformatf("tbl%0d_d4_pend", i), d4_pend, tbl[i].pend4);
      chk($sformatf("tbl%0d_d4_ovr", i),  d4_ovr,  tbl[i].ovr4);
      chk($sformatf("tbl%0d_d1_dout", i), d1_dout, (q1.size() > 0) ? q1[0] : last1);
      chk($sformatf("tbl%0d_d1_pend", i), d1_pend, q1.size() > 0);
    end

    // IRQ: basic request, acknowledge, level held high
    sndon = 1'b1; tick();
    check_irq("irq_d1", 1'b1, 1'b0);
    tick();
    check_irq("irq_d2", 1'b0, 1'b0);
    z80_m1_n = 1'b0; z80_iorq_n = 1'b0; tick();
    check_irq("irq_ack", 1'b1, 1'b1);
    z80_m1_n = 1'b1; z80_iorq_n = 1'b1; tick();
    check_irq("irq_idle", 1'b1, 1'b0);
    repeat (4) tick();
    check_irq("irq_level", 1'b1, 1'b0);

    // toggles during ACK: exactly one more IRQ
    sndon = 1'b0; tick(); tick();
    sndon = 1'b1; tick(); tick();
    check_irq("ackt_assert", 1'b0, 1'b0);
    z80_m1_n = 1'b0; z80_iorq_n = 1'b0; tick();
    sndon = 1'b0; tick();
    sndon = 1'b1; tick();
    sndon = 1'b0; tick();
    sndon = 1'b1; tick();
    check_irq("ackt_inack", 1'b1, 1'b1);
    z80_m1_n = 1'b1; z80_iorq_n = 1'b1; tick();
    check_irq("ackt_idle", 1'b1, 1'b0);
    tick();
    check_irq("ackt_reassert", 1'b0, 1'b0);
    ack_cycle();
    repeat (4) tick();
    check_irq("ackt_single", 1'b1, 1'b0);

    // toggles during ASSERT: merged
    sndon = 1'b0; tick(); tick();
    sndon = 1'b1; tick(); tick();
    check_irq("mrg_assert", 1'b0, 1'b0);
    sndon = 1'b0; tick();
    sndon = 1'b1; tick();
    sndon = 1'b0; tick();
    sndon = 1'b1; tick(); tick();
    check_irq("mrg_still", 1'b0, 1'b0);
    ack_cycle();
    repeat (4) tick();
    check_irq("mrg_single", 1'b1, 1'b0);
    sndon = 1'b0; tick(); tick();

    // randomized traffic against the queue models
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0: do_write(8'($urandom), int'($urandom_range(1, 3)));
        1: do_read();
        2: do_both(8'($urandom));
        default: repeat ($urandom_range(1, 3)) tick();
      endcase
      check_data($sformatf("rnd%0d", n));
    end

    // reset in the middle of activity
    repeat (5) do_read();
    do_write(8'hA1, 1);
    do_write(8'hB2, 2);
    check_data("pre_rst");
    sndon = 1'b1; tick(); tick();
    check_irq("pre_rst", 1'b0, 1'b0);
    cpu_din = 8'hCC; snddt_n = 1'b0; tick(); tick();
    reset = 1'b1; #1;
    m_reset();
    check_data("in_rst");
    check_irq("in_rst", 1'b1, 1'b0);
    chk("in_rst_vec", d4_vec, 8'hFF);
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();
    snddt_n = 1'b1;
    repeat (3) tick();
    check_data("post_rst");
    check_irq("post_rst", 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
